// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Size depends only on funct3[1:0]; the reserved encodings fall into word.
  function automatic lsu_size_e decode_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] lane_offset(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_enables(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
      default: return '1;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane shift and sign/zero extension of the raw bus read word.
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned WORDSIZE = 32
) (
  input  logic [WORDSIZE-1:0] busRData,
  input  logic [1:0]          addrLow,
  input  logic [2:0]          funct3,
  output logic [WORDSIZE-1:0] loadData
);

  logic [WORDSIZE-1:0] shifted;

  always_comb begin
    shifted = busRData >> {addrLow, 3'b000};
    case (funct3)
      LB:      loadData = {{(WORDSIZE-8){shifted[7]}}, shifted[7:0]};
      LBU:     loadData = {{(WORDSIZE-8){1'b0}}, shifted[7:0]};
      LH:      loadData = {{(WORDSIZE-16){shifted[15]}}, shifted[15:0]};
      LHU:     loadData = {{(WORDSIZE-16){1'b0}}, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one valid/ready bus transaction per access.
// Optional misaligned trap enabled by LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] address,
  input  logic [WORDSIZE-1:0] storeData,
  output logic [WORDSIZE-1:0] readData,
  output logic                stall,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                misaligned,
`endif
  output logic                busReqValid,
  input  logic                busReqReady,
  output logic                busWrite,
  output logic [WORDSIZE-1:0] busAddr,
  output logic [BE_W-1:0]     busByteEn,
  output logic [WORDSIZE-1:0] busWData,
  input  logic                busRspValid,
  input  logic [WORDSIZE-1:0] busRData
);

  lsu_state_e          state_q, state_d;
  logic                req;
  lsu_size_e           size_in;
  logic [1:0]          off_in;
  logic [WORDSIZE-1:0] wdata_in;
  logic [WORDSIZE-1:0] load_data;

  logic                write_q;
  logic [WORDSIZE-1:0] addr_q;
  logic [BE_W-1:0]     be_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [WORDSIZE-1:0] rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                mis_in;
  logic                mis_q;
`endif

  assign req     = memRead | memWrite;
  assign size_in = decode_size(funct3[1:0]);
  assign off_in  = lane_offset(size_in, address[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_in  = is_misaligned(size_in, address[1:0]);
`endif

  always_comb begin
    case (size_in)
      SZ_BYTE: wdata_in = {(WORDSIZE/8){storeData[7:0]}};
      SZ_HALF: wdata_in = {(WORDSIZE/16){storeData[15:0]}};
      default: wdata_in = storeData;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_d = mis_in ? DONE : REQ;
`else
          state_d = REQ;
`endif
        end
      end
      REQ:     if (busReqReady) state_d = WAIT;
      WAIT:    if (busRspValid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busReqValid = (state_q == REQ);
    stall       = req && (state_q != DONE);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned  = (state_q == DONE) && mis_q;
`endif
  end

  // Request fields are captured once in IDLE so the bus sees them stable through REQ.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && req) begin
        write_q  <= memWrite;
        addr_q   <= {address[WORDSIZE-1:2], 2'b00};
        be_q     <= byte_enables(size_in, address[1:0]);
        wdata_q  <= wdata_in;
        funct3_q <= funct3;
        off_q    <= off_in;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q    <= mis_in;
`endif
      end
      if (state_q == WAIT && busRspValid && !write_q) begin
        rdata_q <= load_data;
      end
    end
  end

  load_align #(
    .WORDSIZE(WORDSIZE)
  ) u_load_align (
    .busRData(busRData),
    .addrLow (off_q),
    .funct3  (funct3_q),
    .loadData(load_data)
  );

  assign readData  = rdata_q;
  assign busWrite  = write_q;
  assign busAddr   = addr_q;
  assign busByteEn = be_q;
  assign busWData  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        rstN;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [31:0] readData;
  logic        stall;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif
  logic        busReqValid;
  logic        busReqReady;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [3:0]  busByteEn;
  logic [31:0] busWData;
  logic        busRspValid;
  logic [31:0] busRData;

  int checks;
  int failures;

  int          ncyc, nst, nreq, nmis;
  logic [31:0] ra, rw;
  logic [3:0]  rbe;
  logic        rwr, uns, to;

  load_store_unit #(
    .WORDSIZE(32)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .address    (address),
    .storeData  (storeData),
    .readData   (readData),
    .stall      (stall),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned (misaligned),
`endif
    .busReqValid(busReqValid),
    .busReqReady(busReqReady),
    .busWrite   (busWrite),
    .busAddr    (busAddr),
    .busByteEn  (busByteEn),
    .busWData   (busWData),
    .busRspValid(busRspValid),
    .busRData   (busRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access and plays the memory side; records what the bus showed.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdat, input int rdy_dly, input int rsp_dly,
                            output int n_cyc, output int n_stall, output int n_req,
                            output int n_mis, output logic [31:0] r_addr,
                            output logic [31:0] r_wdata, output logic [3:0] r_be,
                            output logic r_write, output logic unstable, output logic timeout);
    int   req_cnt;
    int   wait_cnt;
    logic in_wait;
    logic fire;
    n_cyc = 0; n_stall = 0; n_req = 0; n_mis = 0;
    r_addr = '0; r_wdata = '0; r_be = '0; r_write = 1'b0;
    unstable = 1'b0; timeout = 1'b1;
    req_cnt = 0; wait_cnt = 0; in_wait = 1'b0;
    @(negedge clk);
    memRead = rd; memWrite = wr; funct3 = f3; address = addr;
    storeData = sd; busRData = rdat; busReqReady = 1'b0; busRspValid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      n_cyc++;
      fire = 1'b0;
      busReqReady = 1'b0;
      busRspValid = 1'b0;
      if (busReqValid) begin
        if (n_req == 0) begin
          r_addr = busAddr; r_wdata = busWData; r_be = busByteEn; r_write = busWrite;
        end else if (busAddr !== r_addr || busWData !== r_wdata ||
                     busByteEn !== r_be || busWrite !== r_write) begin
          unstable = 1'b1;
        end
        n_req++;
        if (req_cnt >= rdy_dly) begin
          busReqReady = 1'b1;
          fire = 1'b1;
        end
        req_cnt++;
      end else if (in_wait) begin
        if (wait_cnt >= rsp_dly) begin
          busRspValid = 1'b1;
          in_wait = 1'b0;
        end
        wait_cnt++;
      end
      #1;
      if (stall) n_stall++;
`ifdef LSU_MISALIGN_TRAP_EN
      if (misaligned) n_mis++;
`endif
      if (!stall) begin
        timeout = 1'b0;
        break;
      end
      if (fire) in_wait = 1'b1;
      @(negedge clk);
    end
    memRead = 1'b0;
    memWrite = 1'b0;
    busReqReady = 1'b0;
    busRspValid = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = '0; address = '0;
    storeData = '0; busReqReady = 1'b0; busRspValid = 1'b0; busRData = '0;
    #12;
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL rst_readData got=%h exp=0", readData); end
    checks++; if (busReqValid !== 1'b0) begin failures++; $display("FAIL rst_reqValid got=%b exp=0", busReqValid); end
    checks++; if (busWrite !== 1'b0) begin failures++; $display("FAIL rst_busWrite got=%b exp=0", busWrite); end
    checks++; if (busAddr !== 32'h0) begin failures++; $display("FAIL rst_busAddr got=%h exp=0", busAddr); end
    checks++; if (busByteEn !== 4'h0) begin failures++; $display("FAIL rst_byteEn got=%b exp=0000", busByteEn); end
    checks++; if (busWData !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", busWData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%b exp=0", misaligned); end
`endif
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL lw_timeout got=%b exp=0", to); end
    checks++; if (readData !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", readData); end
    checks++; if (ra !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", ra); end
    checks++; if (rbe !== 4'b1111) begin failures++; $display("FAIL lw_be got=%b exp=1111", rbe); end
    checks++; if (rwr !== 1'b0) begin failures++; $display("FAIL lw_write got=%b exp=0", rwr); end
    checks++; if (nst != 3) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=3", nst); end
    checks++; if (ncyc != 4) begin failures++; $display("FAIL lw_cycles got=%0d exp=4", ncyc); end
    checks++; if (nreq != 1) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=1", nreq); end
  endtask

  task automatic test_sub_word_loads();
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (rbe !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", rbe); end
    checks++; if (ra !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", ra); end
    checks++; if (readData !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", readData); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (readData !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", readData); end
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FFFF7F, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (rbe !== 4'b1100) begin failures++; $display("FAIL lh_be got=%b exp=1100", rbe); end
    checks++; if (readData !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff80ff", readData); end
    run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FFFF7F, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (rbe !== 4'b0011) begin failures++; $display("FAIL lhu_be got=%b exp=0011", rbe); end
    checks++; if (readData !== 32'h0000FF7F) begin failures++; $display("FAIL lhu_rdata got=%h exp=0000ff7f", readData); end
  endtask

  task automatic test_stores();
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (ra !== 32'h200) begin failures++; $display("FAIL sh_addr got=%h exp=00000200", ra); end
    checks++; if (rbe !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", rbe); end
    checks++; if (rw !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", rw); end
    checks++; if (rwr !== 1'b1) begin failures++; $display("FAIL sh_write got=%b exp=1", rwr); end
    checks++; if (readData !== 32'h0000FF7F) begin failures++; $display("FAIL sh_rdata_kept got=%h exp=0000ff7f", readData); end
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h55555555, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (rbe !== 4'b0010) begin failures++; $display("FAIL sb_be got=%b exp=0010", rbe); end
    checks++; if (rw !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", rw); end
    run_access(1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h55555555, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (rwr !== 1'b1) begin failures++; $display("FAIL both_write got=%b exp=1", rwr); end
    checks++; if (rw !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_wdata got=%h exp=cafef00d", rw); end
    checks++; if (rbe !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", rbe); end
    checks++; if (readData !== 32'h0000FF7F) begin failures++; $display("FAIL both_rdata_kept got=%h exp=0000ff7f", readData); end
  endtask

  task automatic test_stretched();
    run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h13579BDF, 5, 3,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL str_timeout got=%b exp=0", to); end
    checks++; if (nreq != 6) begin failures++; $display("FAIL str_req_cycles got=%0d exp=6", nreq); end
    checks++; if (uns !== 1'b0) begin failures++; $display("FAIL str_req_stable got=%b exp=0", uns); end
    checks++; if (nst != 11) begin failures++; $display("FAIL str_stall_cycles got=%0d exp=11", nst); end
    checks++; if (ncyc != 12) begin failures++; $display("FAIL str_cycles got=%0d exp=12", ncyc); end
    checks++; if (readData !== 32'h13579BDF) begin failures++; $display("FAIL str_rdata got=%h exp=13579bdf", readData); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h01020304, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (readData !== 32'h01020304) begin failures++; $display("FAIL b2b_first got=%h exp=01020304", readData); end
    run_access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h80000000, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (ncyc != 4) begin failures++; $display("FAIL b2b_cycles got=%0d exp=4", ncyc); end
    checks++; if (nst != 3) begin failures++; $display("FAIL b2b_stall got=%0d exp=3", nst); end
    checks++; if (readData !== 32'hFFFF8000) begin failures++; $display("FAIL b2b_second got=%h exp=ffff8000", readData); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    memRead = 1'b1; funct3 = 3'b010; address = 32'h500; busRData = 32'h0;
    busReqReady = 1'b1; busRspValid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busReqValid !== 1'b1) begin failures++; $display("FAIL rmid_in_req got=%b exp=1", busReqValid); end
    @(negedge clk);
    memRead = 1'b0; busReqReady = 1'b0; rstN = 1'b0;
    #1;
    checks++; if (busReqValid !== 1'b0) begin failures++; $display("FAIL rmid_reqValid got=%b exp=0", busReqValid); end
    checks++; if (busAddr !== 32'h0) begin failures++; $display("FAIL rmid_busAddr got=%h exp=0", busAddr); end
    checks++; if (busByteEn !== 4'h0) begin failures++; $display("FAIL rmid_byteEn got=%b exp=0000", busByteEn); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL rmid_readData got=%h exp=0", readData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%b exp=0", stall); end
    @(negedge clk);
    rstN = 1'b1; busRspValid = 1'b1; busRData = 32'hFFFFFFFF;
    @(negedge clk);
    busRspValid = 1'b0;
    #1;
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL rmid_late_rsp got=%h exp=0", readData); end
    checks++; if (busReqValid !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", busReqValid); end
    run_access(1'b1, 1'b0, 3'b100, 32'h501, 32'h0, 32'h0000AB00, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (readData !== 32'h000000AB) begin failures++; $display("FAIL rmid_recover got=%h exp=000000ab", readData); end
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
    checks++; if (readData !== 32'h0BADF00D) begin failures++; $display("FAIL mis_pre got=%h exp=0badf00d", readData); end
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (nreq != 0) begin failures++; $display("FAIL mis_lw_req got=%0d exp=0", nreq); end
    checks++; if (nmis != 1) begin failures++; $display("FAIL mis_lw_flag got=%0d exp=1", nmis); end
    checks++; if (ncyc != 2) begin failures++; $display("FAIL mis_lw_cycles got=%0d exp=2", ncyc); end
    checks++; if (readData !== 32'h0BADF00D) begin failures++; $display("FAIL mis_lw_rdata got=%h exp=0badf00d", readData); end
    @(negedge clk);
    #1;
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_lw_after got=%b exp=0", misaligned); end
`else
    checks++; if (ra !== 32'h100) begin failures++; $display("FAIL mis_lw_addr got=%h exp=00000100", ra); end
    checks++; if (rbe !== 4'b1111) begin failures++; $display("FAIL mis_lw_be got=%b exp=1111", rbe); end
    checks++; if (readData !== 32'h11223344) begin failures++; $display("FAIL mis_lw_rdata got=%h exp=11223344", readData); end
`endif
    run_access(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h11223344, 0, 0,
               ncyc, nst, nreq, nmis, ra, rw, rbe, rwr, uns, to);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (nreq != 0) begin failures++; $display("FAIL mis_lh_req got=%0d exp=0", nreq); end
    checks++; if (readData !== 32'h0BADF00D) begin failures++; $display("FAIL mis_lh_rdata got=%h exp=0badf00d", readData); end
`else
    checks++; if (rbe !== 4'b1100) begin failures++; $display("FAIL mis_lh_be got=%b exp=1100", rbe); end
    checks++; if (readData !== 32'h00001122) begin failures++; $display("FAIL mis_lh_rdata got=%h exp=00001122", readData); end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_stretched();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
